// File: rtl/count_seq_monitor_pkg.sv
// Shared definitions for the count sequence monitor: FSM encoding and default sizing.
package count_seq_monitor_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2
    } mon_state_t;

    localparam int DEF_WIDTH      = 3;
    localparam int DEF_SYNC_LEN   = 2;
    localparam int DEF_WRAP_CNT_W = 8;
    localparam int DEF_ERR_CNT_W  = 8;
    // Match counter width; holds any SYNC_LEN up to 15
    localparam int MATCH_W        = 4;

endpackage

// File: rtl/count_seq_monitor_if.sv
// Monitor-side bus: sampled counter stream and clear in, lock/error/wrap status out.
interface count_seq_monitor_if
    import count_seq_monitor_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int WRAP_CNT_W = DEF_WRAP_CNT_W,
    parameter int ERR_CNT_W  = DEF_ERR_CNT_W
);
    logic                  step;
    logic [WIDTH-1:0]      count_in;
    logic                  clr;
    logic                  locked;
    logic                  err_pulse;
    logic                  err_sticky;
    logic                  wrap_pulse;
    logic [WRAP_CNT_W-1:0] wrap_cnt;
    logic [ERR_CNT_W-1:0]  err_cnt;
    logic [WIDTH-1:0]      last_bad;

    modport master (
        output step, count_in, clr,
        input  locked, err_pulse, err_sticky, wrap_pulse, wrap_cnt, err_cnt, last_bad
    );

    modport slave (
        input  step, count_in, clr,
        output locked, err_pulse, err_sticky, wrap_pulse, wrap_cnt, err_cnt, last_bad
    );
endinterface

// File: rtl/count_seq_monitor_seq_stat_counter.sv
// Statistics counter with synchronous clear and either saturating or rollover increment.
module seq_stat_counter #(
    parameter int W        = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] r_cnt;
    logic         w_full;

    assign w_full = &r_cnt;

    // An increment landing with a clear counts after the clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= i_inc ? {{(W-1){1'b0}}, 1'b1} : '0;
        else if (i_inc && !(SATURATE && w_full))
            r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/count_seq_monitor.sv
// Locks onto a +1/hold count stream and reports skipped, stuck or corrupted values.
module count_seq_monitor
    import count_seq_monitor_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int SYNC_LEN   = DEF_SYNC_LEN,
    parameter int WRAP_CNT_W = DEF_WRAP_CNT_W,
    parameter int ERR_CNT_W  = DEF_ERR_CNT_W
) (
    input  logic          clk,
    input  logic          reset,
    count_seq_monitor_if.slave mon
);
    mon_state_t           r_state;
    logic [WIDTH-1:0]     r_prev;
    logic [MATCH_W-1:0]   r_match;
    logic                 r_locked;
    logic                 r_err_pulse;
    logic                 r_err_sticky;
    logic                 r_wrap_pulse;
    logic [WIDTH-1:0]     r_last_bad;

    logic [WIDTH-1:0]     w_exp;
    logic [MATCH_W-1:0]   w_match_inc;
    logic                 w_good;
    logic                 w_err;
    logic                 w_wrap;

    assign w_exp       = mon.step ? r_prev + WIDTH'(1) : r_prev;
    assign w_good      = (mon.count_in == w_exp);
    assign w_match_inc = r_match + MATCH_W'(1);
    assign w_err       = (r_state == ST_LOCK) && !w_good;
    // A good stepped sample out of all-ones is necessarily 0, so that is the wrap
    assign w_wrap      = (r_state == ST_LOCK) && w_good && mon.step && (&r_prev);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_INIT;
            r_prev       <= '0;
            r_match      <= '0;
            r_locked     <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_err_sticky <= 1'b0;
            r_wrap_pulse <= 1'b0;
            r_last_bad   <= '0;
        end else begin
            r_prev       <= mon.count_in;
            r_err_pulse  <= w_err;
            r_wrap_pulse <= w_wrap;

            if (w_err)
                r_err_sticky <= 1'b1;
            else if (mon.clr)
                r_err_sticky <= 1'b0;

            if (w_err)
                r_last_bad <= mon.count_in;
            else if (mon.clr)
                r_last_bad <= '0;

            case (r_state)
                ST_INIT: begin
                    r_state <= ST_ACQ;
                    r_match <= '0;
                end
                ST_ACQ: begin
                    if (!w_good)
                        r_match <= '0;
                    else if (w_match_inc == MATCH_W'(SYNC_LEN)) begin
                        r_state  <= ST_LOCK;
                        r_locked <= 1'b1;
                        r_match  <= '0;
                    end else
                        r_match <= w_match_inc;
                end
                ST_LOCK: begin
                    if (!w_good) begin
                        r_state  <= ST_ACQ;
                        r_locked <= 1'b0;
                        r_match  <= '0;
                    end
                end
                default: begin
                    r_state  <= ST_INIT;
                    r_locked <= 1'b0;
                    r_match  <= '0;
                end
            endcase
        end
    end

    seq_stat_counter #(.W(WRAP_CNT_W), .SATURATE(1'b0)) u_wrap_cnt (
        .clk   (clk),
        .reset (reset),
        .i_clr (mon.clr),
        .i_inc (w_wrap),
        .o_cnt (mon.wrap_cnt)
    );

    seq_stat_counter #(.W(ERR_CNT_W), .SATURATE(1'b1)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .i_clr (mon.clr),
        .i_inc (w_err),
        .o_cnt (mon.err_cnt)
    );

    assign mon.locked     = r_locked;
    assign mon.err_pulse  = r_err_pulse;
    assign mon.err_sticky = r_err_sticky;
    assign mon.wrap_pulse = r_wrap_pulse;
    assign mon.last_bad   = r_last_bad;
endmodule

// File: tb/tb_count_seq_monitor.sv
// Randomized and directed bench for count_seq_monitor against a rule-level reference model.
module tb_count_seq_monitor;
    localparam int SYNC_LEN = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    count_seq_monitor_if #(.WIDTH(3), .WRAP_CNT_W(8), .ERR_CNT_W(8)) mon_if ();

    count_seq_monitor #(.WIDTH(3), .SYNC_LEN(SYNC_LEN), .WRAP_CNT_W(8), .ERR_CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .mon   (mon_if)
    );

    int vecs = 0;
    int miscmp = 0;

    // Reference model state: derived from the sequence rules, not the RTL encoding
    bit       m_seen, m_lock, m_errp, m_sticky, m_wrapp;
    int       m_run;
    logic [2:0] m_prev, m_lastbad;
    logic [7:0] m_wcnt, m_ecnt;
    logic [2:0] cur;

    logic [22:0] dut_st, exp_st;
    assign dut_st = {mon_if.locked, mon_if.err_pulse, mon_if.err_sticky, mon_if.wrap_pulse,
                     mon_if.wrap_cnt, mon_if.err_cnt, mon_if.last_bad};
    assign exp_st = {m_lock, m_errp, m_sticky, m_wrapp, m_wcnt, m_ecnt, m_lastbad};

    task automatic model_reset();
        m_seen = 0; m_lock = 0; m_errp = 0; m_sticky = 0; m_wrapp = 0;
        m_run = 0; m_prev = 0; m_lastbad = 0; m_wcnt = 0; m_ecnt = 0;
    endtask

    task automatic model_update(input bit st, input logic [2:0] cnt, input bit c);
        logic [2:0] e;
        e = st ? 3'(m_prev + 3'd1) : m_prev;
        m_errp = 0;
        m_wrapp = 0;
        if (c) begin
            m_sticky = 0; m_ecnt = 0; m_wcnt = 0; m_lastbad = 0;
        end
        if (!m_seen)
            m_seen = 1;
        else if (m_lock) begin
            if (cnt == e) begin
                if (st && m_prev == 3'd7) begin
                    m_wrapp = 1;
                    m_wcnt = m_wcnt + 8'd1;
                end
            end else begin
                m_errp = 1;
                m_sticky = 1;
                if (m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
                m_lastbad = cnt;
                m_lock = 0;
                m_run = 0;
            end
        end else if (cnt == e) begin
            m_run++;
            if (m_run == SYNC_LEN) begin
                m_lock = 1;
                m_run = 0;
            end
        end else
            m_run = 0;
        m_prev = cnt;
    endtask

    // Applies one sample across one rising edge and advances the model
    task automatic drive(input bit st, input logic [2:0] cnt, input bit c);
        mon_if.step = st;
        mon_if.count_in = cnt;
        mon_if.clr = c;
        @(posedge clk);
        model_update(st, cnt, c);
        #1;
    endtask

    task automatic test_reset();
        mon_if.step = 1'b1; mon_if.count_in = 3'd5; mon_if.clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vecs++;
        if (dut_st !== 23'd0) begin
            miscmp++; $display("FAIL reset_state: got %h expected %h", dut_st, 23'd0);
        end
        reset = 1'b0;
    endtask

    task automatic test_lock_wrap();
        cur = 3'd0;
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, cur, 1'b0);
            cur = cur + 3'd1;
            vecs++;
            if (dut_st !== exp_st) begin
                miscmp++; $display("FAIL lock_wrap[%0d]: got %h expected %h", i, dut_st, exp_st);
            end
            if (i == 1 || i == 2) begin
                vecs++;
                if (mon_if.locked !== (i == 2)) begin
                    miscmp++; $display("FAIL lock_edge[%0d]: got %b expected %b", i, mon_if.locked, i == 2);
                end
            end
        end
        vecs++;
        if (mon_if.wrap_cnt !== 8'd1 || mon_if.err_cnt !== 8'd0) begin
            miscmp++; $display("FAIL first_wrap: got wrap=%0d err=%0d expected wrap=1 err=0",
                                mon_if.wrap_cnt, mon_if.err_cnt);
        end
    endtask

    task automatic test_skip();
        logic [2:0] seq [5] = '{3'd3, 3'd4, 3'd6, 3'd7, 3'd0};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, seq[i], 1'b0);
            vecs++;
            if (dut_st !== exp_st) begin
                miscmp++; $display("FAIL skip[%0d]: got %h expected %h", i, dut_st, exp_st);
            end
            if (i == 2) begin
                vecs++;
                if ({mon_if.err_pulse, mon_if.locked, mon_if.last_bad, mon_if.err_cnt} !== {1'b1, 1'b0, 3'd6, 8'd1}) begin
                    miscmp++; $display("FAIL skip_err: got pulse=%b lock=%b bad=%0d cnt=%0d expected 1 0 6 1",
                                        mon_if.err_pulse, mon_if.locked, mon_if.last_bad, mon_if.err_cnt);
                end
            end
        end
        vecs++;
        if (mon_if.locked !== 1'b1 || mon_if.err_pulse !== 1'b0) begin
            miscmp++; $display("FAIL skip_relock: got lock=%b pulse=%b expected 1 0", mon_if.locked, mon_if.err_pulse);
        end
        cur = 3'd1;
    endtask

    task automatic test_hold();
        while (cur != 3'd6) begin
            drive(1'b1, cur, 1'b0);
            cur = cur + 3'd1;
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 3'd5, 1'b0);
            vecs++;
            if (dut_st !== exp_st || mon_if.locked !== 1'b1 || mon_if.err_pulse !== 1'b0) begin
                miscmp++; $display("FAIL hold[%0d]: got %h expected %h", i, dut_st, exp_st);
            end
        end
        drive(1'b0, 3'd6, 1'b0);
        vecs++;
        if (dut_st !== exp_st || mon_if.err_pulse !== 1'b1 || mon_if.last_bad !== 3'd6) begin
            miscmp++; $display("FAIL hold_change: got %h expected %h", dut_st, exp_st);
        end
        drive(1'b1, 3'd7, 1'b0);
        drive(1'b1, 3'd0, 1'b0);
        cur = 3'd1;
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 260; i++) begin
            cur = cur + 3'd2;
            drive(1'b1, cur, 1'b0);
            vecs++;
            if (dut_st !== exp_st) begin
                miscmp++; $display("FAIL sat_err[%0d]: got %h expected %h", i, dut_st, exp_st);
            end
            for (int k = 0; k < 2; k++) begin
                cur = cur + 3'd1;
                drive(1'b1, cur, 1'b0);
            end
            vecs++;
            if (dut_st !== exp_st) begin
                miscmp++; $display("FAIL sat_relock[%0d]: got %h expected %h", i, dut_st, exp_st);
            end
        end
        vecs++;
        if (mon_if.err_cnt !== 8'hFF || mon_if.err_sticky !== 1'b1) begin
            miscmp++; $display("FAIL sat_value: got cnt=%0d sticky=%b expected 255 1", mon_if.err_cnt, mon_if.err_sticky);
        end
        cur = cur + 3'd1;
        drive(1'b1, cur, 1'b1);
        vecs++;
        if (mon_if.err_cnt !== 8'd0 || mon_if.err_sticky !== 1'b0 || mon_if.locked !== 1'b1 || dut_st !== exp_st) begin
            miscmp++; $display("FAIL sat_clr: got %h expected %h", dut_st, exp_st);
        end
    endtask

    task automatic test_clr_with_err();
        cur = cur + 3'd3;
        drive(1'b1, cur, 1'b1);
        vecs++;
        if ({mon_if.err_cnt, mon_if.err_sticky, mon_if.wrap_cnt} !== {8'd1, 1'b1, 8'd0} || dut_st !== exp_st) begin
            miscmp++; $display("FAIL clr_with_err: got %h expected %h", dut_st, exp_st);
        end
        for (int k = 0; k < 2; k++) begin
            cur = cur + 3'd1;
            drive(1'b1, cur, 1'b0);
        end
    endtask

    task automatic test_random();
        bit st, c;
        logic [2:0] v;
        for (int i = 0; i < 400; i++) begin
            st = 1'($urandom_range(0, 1));
            v = st ? cur + 3'd1 : cur;
            if ($urandom_range(0, 7) == 0) v = 3'($urandom_range(0, 7));
            c = ($urandom_range(0, 31) == 0);
            drive(st, v, c);
            cur = v;
            vecs++;
            if (dut_st !== exp_st) begin
                miscmp++; $display("FAIL random[%0d]: got %h expected %h", i, dut_st, exp_st);
            end
        end
    endtask

    task automatic test_mid_reset();
        int budget;
        drive(1'b0, cur, 1'b1);
        for (int k = 0; k < 2; k++) begin
            cur = cur + 3'd1;
            drive(1'b1, cur, 1'b0);
        end
        budget = 0;
        while (m_wcnt != 8'd5 && budget < 60) begin
            cur = cur + 3'd1;
            drive(1'b1, cur, 1'b0);
            budget++;
        end
        vecs++;
        if (mon_if.wrap_cnt !== 8'd5 || mon_if.locked !== 1'b1) begin
            miscmp++; $display("FAIL pre_reset: got wrap=%0d lock=%b expected 5 1", mon_if.wrap_cnt, mon_if.locked);
        end
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        vecs++;
        if (dut_st !== 23'd0) begin
            miscmp++; $display("FAIL async_reset: got %h expected %h", dut_st, 23'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        cur = 3'd0;
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, cur, 1'b0);
            cur = cur + 3'd1;
            vecs++;
            if (dut_st !== exp_st) begin
                miscmp++; $display("FAIL post_reset[%0d]: got %h expected %h", i, dut_st, exp_st);
            end
            if (i == 2) begin
                vecs++;
                if (mon_if.locked !== 1'b1 || mon_if.wrap_cnt !== 8'd0) begin
                    miscmp++; $display("FAIL relock_after_reset: got lock=%b wrap=%0d expected 1 0",
                                        mon_if.locked, mon_if.wrap_cnt);
                end
            end
        end
        vecs++;
        if (mon_if.wrap_cnt !== 8'd1) begin
            miscmp++; $display("FAIL wrap_restart: got %0d expected 1", mon_if.wrap_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_lock_wrap();
        test_skip();
        test_hold();
        test_saturate();
        test_clr_with_err();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end
endmodule

// File: doc/count_seq_monitor.md
Name: count_seq_monitor

Overview:
- Downstream checker for the team's 3-bit synchronous JK-flip-flop counter (sync_3); consumes its count bus every clock.
- Acquires lock on the expected +1 mod 2^WIDTH sequence and flags any skipped, stuck or corrupted value once locked.
- Keeps wrap and error statistics for status readback and bench self-checking.

Parameters:
- WIDTH, 3, width of monitored count bus
- SYNC_LEN, 2, consecutive correct transitions required to enter LOCK (legal range 1..15)
- WRAP_CNT_W, 8, width of wrap counter (rolls over modulo 2^WRAP_CNT_W)
- ERR_CNT_W, 8, width of error counter (saturates at all-ones)

Ports:
- clk  in  1  rising-edge clock, same clock as the upstream counter
- reset  in  1  asynchronous, active-high reset
- step  in  1  1 = upstream counter advances this cycle (expect prev+1); 0 = hold (expect prev)
- count_in  in  WIDTH  count bus from upstream counter
- clr  in  1  synchronous clear of statistics and sticky flag
- locked  out  1  high while FSM is in LOCK
- err_pulse  out  1  one-cycle pulse per sequence error detected in LOCK
- err_sticky  out  1  set on any error, held until clr or reset
- wrap_pulse  out  1  one-cycle pulse per observed max->0 transition in LOCK
- wrap_cnt  out  WRAP_CNT_W  number of wraps observed in LOCK
- err_cnt  out  ERR_CNT_W  number of errors, saturating
- last_bad  out  WIDTH  count_in value of the most recent error

Behaviour:
- Reset: clk is the clock; reset is asynchronous, active-high. While reset is asserted, FSM = INIT, prev = 0, match count = 0, and every output is 0.
- All outputs are registered. A sample presented before edge k produces its responses in the cycle following edge k (latency 1).
- Expected value: exp = step ? (prev + 1) mod 2^WIDTH : prev. Sample is good iff count_in == exp. prev <= count_in on every edge out of reset.
- FSM states:
  - INIT: captures first sample into prev, performs no check, then goes to ACQ.
  - ACQ: good sample increments match count; bad sample clears it with no error reported. When match count reaches SYNC_LEN, go to LOCK and assert locked in the same registered update.
  - LOCK: good sample stays in LOCK. Bad sample: err_pulse=1, err_sticky=1, err_cnt+1 (saturating), last_bad=count_in; then go to ACQ with match count 0 and locked=0.
- Wrap: only in LOCK. A good sample with step=1, prev = all-ones and count_in = 0 gives wrap_pulse=1 and wrap_cnt+1, rolling over modulo 2^WRAP_CNT_W. A bad sample never counts as a wrap.
- clr: clears err_sticky, err_cnt, wrap_cnt and last_bad. It does not affect FSM, prev, match count or locked. If an event occurs in the same cycle as clr, the event is applied after the clear (e.g. err_cnt=1, err_sticky=1).
- Mid-operation reset: immediate return to INIT with all outputs 0; no partial statistics are retained.
- step=0 with count_in unchanged is good (hold). step=0 with any change is bad.
- err_cnt at all-ones stays all-ones; err_pulse and last_bad still update.

Decomposition:
- Shared package: FSM state encoding (INIT, ACQ, LOCK) and default parameter constants.
- One natural sub-module, seq_stat_counter: an N-bit counter with a synchronous clear, selectable saturate/rollover mode, and an increment input. It is instantiated twice, as the wrap counter and the error counter.

Test Plan:
- Reset release, sync_3 free-running, step=1: locked rises in the cycle after the 3rd sample edge (INIT + 2 good). After 8 further cycles wrap_cnt=1, err_cnt=0.
- Locked, inject count sequence 3,4,6: err_pulse for one cycle on the 6 sample. last_bad=6, err_cnt=1, locked=0, relock after 2 good samples (7,0).
- Locked, step=0 for 3 cycles with count held at 5: no error, locked stays 1. Then change count to 6 while step=0: error with last_bad=6.
- Force 260 errors, each followed by relock: err_cnt saturates at 255 and err_sticky=1. Then clr=1: err_cnt=0, err_sticky=0, locked unchanged.
- clr in the same cycle as a detected error: err_cnt=1, err_sticky=1, wrap_cnt=0.
- Assert reset mid-LOCK with wrap_cnt=5: all outputs 0 immediately (asynchronous). After release, the monitor relocks and wrap_cnt restarts from 0.
